pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload through DEPTH register slots.
- Adds valid/ready flow control, stall (back-pressure), flush (bubble insertion), an optional skid buffer and an occupancy count.
- One instance replaces each hand-written stage register. The hazard unit drives flush/out_ready.

Parameters:
- CTRL_W, 2, width of control field (e.g. memtoreg, regwrite); zeroed whenever its slot is invalid.
- DATA_W, 69, width of payload (e.g. 32 rd + 32 aluresult + 5 writereg); never cleared except by reset.
- DEPTH, 1, number of register slots in series (1..4).
- SKID, 0, 1 = add one-entry input skid buffer so in_ready is purely registered.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  this block accepts the entry this cycle
- in_ctrl  in  CTRL_W  control field of incoming entry
- in_data  in  DATA_W  payload of incoming entry
- flush  in  1  synchronous kill of every held entry
- out_valid  out  1  slot DEPTH-1 holds a valid entry
- out_ready  in  1  downstream accepts; 0 = stall
- out_ctrl  out  CTRL_W  control field of slot DEPTH-1 (0 when out_valid=0)
- out_data  out  DATA_W  payload of slot DEPTH-1
- count  out  3  valid entries held, slots + skid (0..DEPTH+SKID)

Behaviour:
- Reset (async, rst=1):
  - All slot valid bits, ctrl fields and data fields go to 0; skid empty.
  - out_valid=0, out_ctrl=0, out_data=0, count=0.
  - in_ready=0 while rst=1.
  - First edge after deassert behaves as an empty pipe.
- Transfers: input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
- Slot i (i<DEPTH-1) advances into slot i+1 when slot i+1 is empty or advancing ("bubble collapse"). Empty slots never block.
- Last slot advances on out_ready.
- SKID=0:
  - in_ready = !valid[0] | advance[0] (combinational through the slot chain from out_ready).
  - Accepted entry is written to slot 0 at the edge.
- SKID=1:
  - in_ready = skid empty, registered, with no combinational path from out_ready.
  - If slot 0 can take the entry, it bypasses the skid. Otherwise it lands in the skid.
  - The skid drains into slot 0 with priority over in_data. in_ready is 0 while the skid is full.
- Latency: with out_ready=1 and no stall, an entry accepted at edge N has out_valid=1 after edge N+DEPTH-1. Accepted edge = write into slot 0.
- Throughput: 1 entry/cycle sustained with out_ready=1, for both SKID values.
- Stall (out_ready=0): last slot holds its value; earlier slots fill bubbles then hold; all held ctrl/data are bit-stable.
- Flush:
  - At the edge, all valid bits clear, all ctrl fields become 0 and the skid empties. Data fields may retain stale values.
  - in_ready is forced 0 during the flush cycle, so a concurrent in_valid entry is not accepted; upstream must retry or drop it.
  - An output handshake in the flush cycle completes normally, since out_valid is a pre-flush register value.
- Ctrl zeroing: any slot written as invalid (bubble or flush) gets ctrl=0. Downstream writeback can therefore gate on ctrl alone.
- count:
  - Updated at each edge: +1 on input handshake, −1 on output handshake, net 0 when both occur.
  - Goes to 0 on flush regardless of other handshakes.
  - Never exceeds DEPTH+SKID.
- Simultaneous full and stall: in_ready=0. When the last slot leaves and in_valid=1 in the same cycle, entry acceptance is governed by the in_ready rules above (yes for SKID=0; for SKID=1, only if the skid is empty).
- Reset asserted mid-stream: all entries are discarded immediately, with no partial transfer.

Test Plan:
- DEPTH=1, SKID=0, out_ready=1: push ctrl=2'b11, data=0x1234 → out_valid=1, out_ctrl=2'b11 next cycle; count 0→1→0 across the stream.
- DEPTH=3, 10 back-to-back entries (data=1..10), out_ready=1 → first out_valid 2 cycles after first accept; outputs 1..10 in order, no gaps.
- DEPTH=2, SKID=1, out_ready=0 for 4 cycles under continuous in_valid → exactly 3 accepted, in_ready=0 afterwards, count=3; release → 3 entries emerge in order, count returns to 0.
- DEPTH=3, full, flush=1 with in_valid=1 → in_ready=0 that cycle; next cycle out_valid=0, out_ctrl=0, count=0.
- Flush in the same cycle as an output handshake of data=0xAA → 0xAA counted as delivered; nothing else emerges.
- Assert rst asynchronously mid-cycle with 2 entries held → out_valid, out_ctrl, out_data and count go to 0 before the next edge; in_ready=0 until rst falls.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register. It carries a
//               control field and a data payload through DEPTH slots in
//               series, with valid/ready flow control, stall, flush (bubble
//               insertion), an optional one-entry input skid buffer and an
//               occupancy count.
//
// Parameters  : CTRL_W - control field width (zeroed in every invalid slot)
//               DATA_W - payload width (cleared only by reset)
//               DEPTH  - number of register slots in series (1..4)
//               SKID   - 1 = one-entry input skid buffer, registered in_ready
//
// Ports       : clk       in   rising-edge clock
//               rst       in   asynchronous active-high reset
//               in_valid  in   upstream presents an entry
//               in_ready  out  entry accepted this cycle when in_valid=1
//               in_ctrl   in   control field of the incoming entry
//               in_data   in   payload of the incoming entry
//               flush     in   synchronous kill of every held entry
//               out_valid out  last slot holds a valid entry
//               out_ready in   downstream accepts; 0 = stall
//               out_ctrl  out  control field of the last slot (0 if invalid)
//               out_data  out  payload of the last slot
//               count     out  valid entries held (slots + skid)
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int DEPTH  = 1,
    parameter int SKID   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        count
);

    localparam int c_last = DEPTH - 1;

    // ------------------------------------------------------------------------
    // Slot storage and next-state
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [CTRL_W-1:0] r_ctrl      [DEPTH];
    logic [CTRL_W-1:0] w_ctrl_nxt  [DEPTH];
    logic [DATA_W-1:0] r_data      [DEPTH];
    logic [DATA_W-1:0] w_data_nxt  [DEPTH];

    // w_take[i]: slot i may be overwritten at the next edge, either because
    // it is empty or because its current entry moves on.
    logic [DEPTH-1:0]  w_take;

    // Entry presented to slot 0 (skid content or the live input)
    logic              w_src_valid;
    logic [CTRL_W-1:0] w_src_ctrl;
    logic [DATA_W-1:0] w_src_data;

    logic              w_in_ready;
    logic              w_in_hs;
    logic              w_out_hs;

    logic [2:0]        r_count;
    logic [2:0]        w_count_nxt;

    assign w_in_hs  = in_valid & w_in_ready;
    assign w_out_hs = r_valid[c_last] & out_ready;

    // ------------------------------------------------------------------------
    // Bubble-collapsing take chain. A slot advances when its successor can
    // take, so take[i] = !valid[i] | take[i+1], with take[DEPTH] = out_ready.
    // Empty slots therefore never block anything upstream of them.
    // ------------------------------------------------------------------------
    always_comb begin : p_take_chain
        logic l_take;
        l_take = out_ready;
        w_take = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            l_take    = !r_valid[i] | l_take;
            w_take[i] = l_take;
        end
    end

    // ------------------------------------------------------------------------
    // Input side: with or without skid buffer
    // ------------------------------------------------------------------------
    if (SKID != 0) begin : g_skid
        logic              r_skid_valid;
        logic [CTRL_W-1:0] r_skid_ctrl;
        logic [DATA_W-1:0] r_skid_data;
        logic              w_skid_valid_nxt;
        logic [CTRL_W-1:0] w_skid_ctrl_nxt;
        logic [DATA_W-1:0] w_skid_data_nxt;

        // Ready depends only on the skid register (plus flush/reset gating),
        // never on out_ready, which breaks the long backward ready path.
        assign w_in_ready = !r_skid_valid & !flush & !rst;

        // A held skid entry drains first; the input bypasses only when the
        // skid is empty.
        assign w_src_valid = r_skid_valid | w_in_hs;
        assign w_src_ctrl  = r_skid_valid ? r_skid_ctrl : in_ctrl;
        assign w_src_data  = r_skid_valid ? r_skid_data : in_data;

        always_comb begin
            w_skid_valid_nxt = r_skid_valid;
            w_skid_ctrl_nxt  = r_skid_ctrl;
            w_skid_data_nxt  = r_skid_data;
            if (flush) begin
                w_skid_valid_nxt = 1'b0;
                w_skid_ctrl_nxt  = '0;
            end else if (r_skid_valid) begin
                if (w_take[0]) begin
                    w_skid_valid_nxt = 1'b0;
                    w_skid_ctrl_nxt  = '0;
                end
            end else if (w_in_hs && !w_take[0]) begin
                // Slot 0 cannot take the accepted entry: park it here.
                w_skid_valid_nxt = 1'b1;
                w_skid_ctrl_nxt  = in_ctrl;
                w_skid_data_nxt  = in_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
                r_skid_data  <= '0;
            end else begin
                r_skid_valid <= w_skid_valid_nxt;
                r_skid_ctrl  <= w_skid_ctrl_nxt;
                r_skid_data  <= w_skid_data_nxt;
            end
        end
    end else begin : g_no_skid
        // Ready ripples combinationally from out_ready through the chain.
        assign w_in_ready  = w_take[0] & !flush & !rst;
        assign w_src_valid = w_in_hs;
        assign w_src_ctrl  = in_ctrl;
        assign w_src_data  = in_data;
    end

    // ------------------------------------------------------------------------
    // Slot next-state. A slot written as a bubble gets ctrl=0 so downstream
    // logic can gate on ctrl alone; data is only loaded with valid entries.
    // ------------------------------------------------------------------------
    always_comb begin
        w_valid_nxt = r_valid;
        for (int i = 0; i < DEPTH; i++) begin
            w_ctrl_nxt[i] = r_ctrl[i];
            w_data_nxt[i] = r_data[i];
        end

        if (flush) begin
            w_valid_nxt = '0;
            for (int i = 0; i < DEPTH; i++) begin
                w_ctrl_nxt[i] = '0;
            end
        end else begin
            if (w_take[0]) begin
                w_valid_nxt[0] = w_src_valid;
                w_ctrl_nxt[0]  = w_src_valid ? w_src_ctrl : '0;
                if (w_src_valid) begin
                    w_data_nxt[0] = w_src_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_take[i]) begin
                    w_valid_nxt[i] = r_valid[i-1];
                    w_ctrl_nxt[i]  = r_valid[i-1] ? r_ctrl[i-1] : '0;
                    if (r_valid[i-1]) begin
                        w_data_nxt[i] = r_data[i-1];
                    end
                end
            end
        end
    end

    // Occupancy: flush wins over any concurrent handshake.
    always_comb begin
        if (flush) begin
            w_count_nxt = 3'd0;
        end else begin
            w_count_nxt = r_count + {2'b00, w_in_hs} - {2'b00, w_out_hs};
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= w_ctrl_nxt[i];
                r_data[i] <= w_data_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_valid[c_last];
    assign out_ctrl  = r_ctrl[c_last];
    assign out_data  = r_data[c_last];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg. Three
//               instances: A (DEPTH=1, SKID=0), B (DEPTH=3, SKID=0),
//               C (DEPTH=2, SKID=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic clk;
    int   total;
    int   bad;

    // Instance A
    logic        rst_a, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [1:0]  a_in_ctrl, a_out_ctrl;
    logic [68:0] a_in_data, a_out_data;
    logic [2:0]  a_count;
    // Instance B
    logic        rst_b, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [1:0]  b_in_ctrl, b_out_ctrl;
    logic [68:0] b_in_data, b_out_data;
    logic [2:0]  b_count;
    // Instance C
    logic        rst_c, c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [1:0]  c_in_ctrl, c_out_ctrl;
    logic [68:0] c_in_data, c_out_data;
    logic [2:0]  c_count;

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .DEPTH(1), .SKID(0)) u_a (
        .clk(clk), .rst(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .count(a_count)
    );

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .DEPTH(3), .SKID(0)) u_b (
        .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .count(b_count)
    );

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .DEPTH(2), .SKID(1)) u_c (
        .clk(clk), .rst(rst_c), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ctrl(c_in_ctrl), .in_data(c_in_data), .flush(c_flush),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl),
        .out_data(c_out_data), .count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_v;
        total = 0;
        bad   = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_in_valid = 0; a_in_ctrl = 0; a_in_data = 0; a_flush = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_ctrl = 0; b_in_data = 0; b_flush = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_ctrl = 0; c_in_data = 0; c_flush = 0; c_out_ready = 0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_in_ready_a",  a_in_ready,  0);
        chk("rst_out_valid_a", a_out_valid, 0);
        chk("rst_count_a",     a_count,     0);
        chk("rst_out_data_b",  b_out_data,  0);
        chk("rst_out_ctrl_b",  b_out_ctrl,  0);
        chk("rst_in_ready_c",  c_in_ready,  0);
        @(posedge clk); #1;
        rst_a = 0; rst_b = 0; rst_c = 0;
        #1;
        chk("idle_in_ready_a", a_in_ready, 1);
        chk("idle_in_ready_c", c_in_ready, 1);

        // ---------------- A: single entry, DEPTH=1 ----------------
        a_in_valid = 1; a_in_ctrl = 2'b11; a_in_data = 69'h1234; a_out_ready = 1;
        #1;
        chk("a_push_in_ready", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 0;
        chk("a_out_valid_1", a_out_valid, 1);
        chk("a_out_ctrl_1",  a_out_ctrl,  2'b11);
        chk("a_out_data_1",  a_out_data,  69'h1234);
        chk("a_count_1",     a_count,     1);
        @(posedge clk); #1;
        chk("a_out_valid_2", a_out_valid, 0);
        chk("a_out_ctrl_2",  a_out_ctrl,  0);
        chk("a_count_2",     a_count,     0);

        // ---------------- B: 10 back-to-back, DEPTH=3 ----------------
        b_out_ready = 1;
        for (int k = 1; k <= 13; k++) begin
            b_in_valid = (k <= 10);
            b_in_data  = 69'(k);
            b_in_ctrl  = 2'b01;
            #1;
            chk("b_stream_in_ready", b_in_ready, 1);
            @(posedge clk); #1;
            exp_v = (k >= 3 && k <= 12);
            chk("b_stream_out_valid", b_out_valid, exp_v);
            chk("b_stream_out_ctrl",  b_out_ctrl,  exp_v ? 2'b01 : 2'b00);
            if (exp_v) begin
                chk("b_stream_out_data", b_out_data, 69'(k - 2));
            end
        end
        b_in_valid = 0;
        chk("b_stream_count_end", b_count, 0);

        // ---------------- B: fill under stall, then flush ----------------
        b_out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            b_in_valid = 1;
            b_in_data  = 69'(8'hA1 + k);
            b_in_ctrl  = 2'b10;
            @(posedge clk); #1;
        end
        b_in_data = 69'hA4;
        #1;
        chk("b_full_stall_in_ready", b_in_ready, 0);
        chk("b_full_count",          b_count,    3);
        chk("b_full_out_data",       b_out_data, 69'hA1);
        b_out_ready = 1;
        #1;
        chk("b_full_release_in_ready", b_in_ready, 1);
        b_out_ready = 0;
        b_flush     = 1;
        #1;
        chk("b_flush_in_ready", b_in_ready, 0);
        @(posedge clk); #1;
        b_flush    = 0;
        b_in_valid = 0;
        chk("b_post_flush_out_valid", b_out_valid, 0);
        chk("b_post_flush_out_ctrl",  b_out_ctrl,  0);
        chk("b_post_flush_count",     b_count,     0);

        // ---------------- A: flush together with output handshake --------
        a_out_ready = 0;
        a_in_valid  = 1; a_in_ctrl = 2'b01; a_in_data = 69'hAA;
        @(posedge clk); #1;
        a_in_data   = 69'hBB;
        a_out_ready = 1;
        a_flush     = 1;
        #1;
        chk("a_flush_hs_out_valid", a_out_valid, 1);
        chk("a_flush_hs_out_data",  a_out_data,  69'hAA);
        chk("a_flush_hs_in_ready",  a_in_ready,  0);
        @(posedge clk); #1;
        a_flush    = 0;
        a_in_valid = 0;
        chk("a_post_flush_out_valid", a_out_valid, 0);
        chk("a_post_flush_out_ctrl",  a_out_ctrl,  0);
        chk("a_post_flush_count",     a_count,     0);
        @(posedge clk); #1;
        chk("a_post_flush_quiet", a_out_valid, 0);

        // ---------------- C: skid fill under stall, DEPTH=2 SKID=1 -------
        c_out_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            c_in_valid = 1;
            c_in_data  = 69'(k);
            c_in_ctrl  = 2'b11;
            #1;
            chk("c_fill_in_ready", c_in_ready, (k <= 3));
            @(posedge clk); #1;
        end
        c_in_valid = 0;
        chk("c_fill_count",    c_count,    3);
        chk("c_fill_in_ready_after", c_in_ready, 0);
        chk("c_fill_out_data", c_out_data, 69'd1);
        c_out_ready = 1;
        for (int k = 2; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("c_drain_out_valid", c_out_valid, 1);
            chk("c_drain_out_data",  c_out_data,  69'(k));
        end
        @(posedge clk); #1;
        chk("c_drain_out_valid_end", c_out_valid, 0);
        chk("c_drain_count_end",     c_count,     0);

        // ---------------- C: asynchronous reset mid-stream ----------------
        c_out_ready = 0;
        c_in_valid  = 1; c_in_ctrl = 2'b11; c_in_data = 69'h55;
        @(posedge clk); #1;
        c_in_data = 69'h66;
        @(posedge clk); #1;
        c_in_valid = 0;
        chk("c_pre_rst_count",    c_count,    2);
        chk("c_pre_rst_out_data", c_out_data, 69'h55);
        #2;
        rst_c = 1;
        #1;
        chk("c_async_rst_out_valid", c_out_valid, 0);
        chk("c_async_rst_out_ctrl",  c_out_ctrl,  0);
        chk("c_async_rst_out_data",  c_out_data,  0);
        chk("c_async_rst_count",     c_count,     0);
        chk("c_async_rst_in_ready",  c_in_ready,  0);
        c_in_valid = 1;
        @(posedge clk); #1;
        chk("c_rst_held_in_ready", c_in_ready, 0);
        rst_c = 0;
        #1;
        chk("c_rst_release_in_ready", c_in_ready, 1);
        c_in_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
